// File: rtl/uart_msg_tx.sv
// -----------------------------------------------------------------------------
// uart_msg_tx
//   UART transmit stage for the pattern/button control block. It takes a
//   one-cycle start request, then sends a right-aligned ASCII message
//   (highest used byte first) as 8N1 frames, or as 8E1 frames when
//   UART_MSG_TX_PARITY_EN is defined.
//
// Configuration macro:
//   UART_MSG_TX_PARITY_EN - adds an even-parity bit between data bit 7 and stop
//
// Parameters:
//   BAUD_DIV  - clocks per UART bit (2..65535)
//   MSG_BYTES - maximum message length in bytes
//   GAP_BITS  - idle bit-times inserted between bytes of one message
//
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   en_uart   - start request; a high cycle in IDLE is accepted
//   read_data - message, right-aligned, first character in the highest used byte
//   nummax    - byte count; values above MSG_BYTES are clamped
//   tx        - UART serial output, idle high
//   busy      - high from the accepted request until message end
//   done      - one-cycle pulse at message end
// -----------------------------------------------------------------------------
module uart_msg_tx #(
    parameter int BAUD_DIV  = 703,
    parameter int MSG_BYTES = 10,
    parameter int GAP_BITS  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_uart,
    input  logic [8*MSG_BYTES-1:0] read_data,
    input  logic [5:0]             nummax,
    output logic                   tx,
    output logic                   busy,
    output logic                   done
);

    localparam int          IDX_W     = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam logic [5:0]  MAX_LEN   = 6'(MSG_BYTES);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_MSG_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        GAP
    } state_t;

    state_t                 state, state_nxt;
    logic [15:0]            baud_cnt, baud_nxt;
    logic [15:0]            gap_cnt, gap_nxt;
    logic [2:0]             bit_cnt, bit_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [8*MSG_BYTES-1:0] data_q, data_nxt;
    logic                   done_nxt;
    logic                   baud_tick;
    logic [5:0]             len_in;
    logic [7:0]             cur_byte;

    assign baud_tick = (baud_cnt == BAUD_LAST);
    assign len_in    = (nummax > MAX_LEN) ? MAX_LEN : nummax;
    // A shift instead of an indexed part-select keeps out-of-range index
    // values (never reached) well defined.
    assign cur_byte  = 8'(data_q >> {idx, 3'b000});
    assign busy      = (state != IDLE);

    // Next-state and counter logic.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        // Every bit boundary and every state change restarts the bit timer.
        baud_nxt  = (state == IDLE || baud_tick) ? 16'd0 : baud_cnt + 16'd1;
        gap_nxt   = gap_cnt;
        bit_nxt   = bit_cnt;
        idx_nxt   = idx;
        data_nxt  = data_q;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (en_uart) begin
                    data_nxt = read_data;
                    if (len_in != 6'd0) begin
                        state_nxt = START;
                        idx_nxt   = IDX_W'(len_in - 6'd1);
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            START: begin
                if (baud_tick) begin
                    state_nxt = DATA;
                    bit_nxt   = 3'd0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt == 3'd7) begin
`ifdef UART_MSG_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_MSG_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    if (idx == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else if (GAP_BITS > 0) begin
                        state_nxt = GAP;
                        gap_nxt   = 16'd0;
                    end else begin
                        state_nxt = START;
                        idx_nxt   = idx - IDX_W'(1);
                    end
                end
            end
            GAP: begin
                // gap_cnt counts whole idle bit-times.
                if (baud_tick) begin
                    if (gap_cnt == GAP_LAST) begin
                        state_nxt = START;
                        idx_nxt   = idx - IDX_W'(1);
                    end else begin
                        gap_nxt = gap_cnt + 16'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Serial output decoded from the registered state; reset forces IDLE,
    // so tx returns high asynchronously.
    always_comb begin
        tx = 1'b1;
        case (state)
            START:  tx = 1'b0;
            DATA:   tx = cur_byte[bit_cnt];
`ifdef UART_MSG_TX_PARITY_EN
            PARITY: tx = ^cur_byte;
`endif
            default: tx = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            gap_cnt  <= '0;
            bit_cnt  <= '0;
            idx      <= '0;
            data_q   <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            gap_cnt  <= gap_nxt;
            bit_cnt  <= bit_nxt;
            idx      <= idx_nxt;
            data_q   <= data_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_msg_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_msg_tx
//   Self-checking bench for uart_msg_tx with BAUD_DIV=4, MSG_BYTES=10,
//   GAP_BITS=0. A serial monitor decodes tx and pops expected bytes from a
//   scoreboard queue; vector records drive whole messages, and hand-written
//   sequences cover the frame waveform, requests while busy, back-to-back
//   messages and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_uart_msg_tx;

    localparam int BD = 4;
`ifdef UART_MSG_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = (10 + P) * BD;
    localparam int LIMIT = 2000;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        en_uart   = 1'b0;
    logic [79:0] read_data = '0;
    logic [5:0]  nummax    = '0;
    logic        tx, busy, done;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    bit   mon_en   = 1'b0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [79:0] data;
        logic [5:0]  num;
        int          exp_n;
        logic [79:0] exp_seq;   // expected bytes in send order, first in [79:72]
    } vec_t;

    vec_t vecs[5];

    uart_msg_tx #(
        .BAUD_DIV (BD),
        .MSG_BYTES(10),
        .GAP_BITS (0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_uart  (en_uart),
        .read_data(read_data),
        .nummax   (nummax),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (P == 1 && j == 9) return ^b;
        return 1'b1;
    endfunction

    // Drive one request; returns #1 after the accept edge (cycle 1).
    // Inputs are scrambled afterwards: the message in flight must not follow them.
    task automatic send_req(input logic [79:0] d, input logic [5:0] n);
        @(negedge clk);
        read_data = d;
        nummax    = n;
        en_uart   = 1'b1;
        @(posedge clk);
        #1;
        en_uart   = 1'b0;
        read_data = 80'({$urandom(), $urandom(), $urandom()});
        nummax    = 6'($urandom());
    endtask

    // Advance until done is seen or the budget runs out; lat is the cycle index.
    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (done !== 1'b1 && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic push_exp(input vec_t v);
        for (int i = 0; i < v.exp_n; i++) exp_q.push_back(v.exp_seq[79-8*i -: 8]);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat, db, bb;
        push_exp(v);
        db = done_cnt;
        bb = busy_cnt;
        send_req(v.data, v.num);
        wait_done(1, lat);
        check({tag, "_latency"}, 32'(lat), 32'(v.exp_n * FRAME + 1));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_done_count"}, 32'(done_cnt - db), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt - bb), 32'(v.exp_n * FRAME));
        check({tag, "_all_bytes"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Serial monitor: samples mid-bit on the falling clock edge.
    initial begin
        logic [7:0] rx;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx === 1'b0) begin
                repeat (BD / 2) @(negedge clk);
                check("mon_start", 32'(tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    rx[i] = tx;
                end
`ifdef UART_MSG_TX_PARITY_EN
                repeat (BD) @(negedge clk);
                check("mon_parity", 32'(tx), 32'(^rx));
`endif
                repeat (BD) @(negedge clk);
                check("mon_stop", 32'(tx), 32'd1);
                check("mon_byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    check("mon_byte", 32'(rx), 32'(exp_b));
                end
            end
        end
    end

    initial begin
        int lat, db;

        vecs[0] = '{"\nA08-2_V4\n", 6'd10, 10, 80'h0A41_3038_2D32_5F56_340A};
        vecs[1] = '{"\n1\n", 6'd3, 3, 80'h0A310A00000000000000};
        vecs[2] = '{"\n1\n", 6'd0, 0, 80'h0};
        vecs[3] = '{80'hF0E1D2C3B4A596877869, 6'd63, 10, 80'hF0E1D2C3B4A596877869};
        vecs[4] = '{80'hDEADBEEF00000000A55A, 6'd2, 2, 80'hA55A0000000000000000};

        // Reset values while reset is held.
        #12;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        // Single byte 8'h0A, cycle-exact waveform.
        exp_q.push_back(8'h0A);
        send_req(80'h0A, 6'd1);
        for (int c = 1; c <= FRAME; c++) begin
            check($sformatf("wave_tx_c%0d", c), 32'(tx), 32'(frame_bit(8'h0A, (c - 1) / BD)));
            check($sformatf("wave_busy_c%0d", c), 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        check("wave_done_rise", 32'(done), 32'd1);
        check("wave_busy_fall", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("wave_done_fall", 32'(done), 32'd0);
        check("wave_tx_idle", 32'(tx), 32'd1);
        check("wave_all_bytes", 32'(exp_q.size()), 32'd0);

        // Message vectors.
        for (int v = 0; v < 5; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

        // Request while busy, issued mid-byte 2, must be ignored.
        db = done_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        send_req(80'h112233, 6'd3);
        repeat (FRAME + FRAME / 2 - 1) @(posedge clk);
        @(negedge clk);
        read_data = "XYZ";
        nummax    = 6'd3;
        en_uart   = 1'b1;
        @(posedge clk);
        #1;
        en_uart = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        wait_done(FRAME + FRAME / 2 + 1, lat);
        check("ign_latency", 32'(lat), 32'(3 * FRAME + 1));
        check("ign_all_bytes", 32'(exp_q.size()), 32'd0);
        // Back-to-back: request in the cycle after done.
        @(posedge clk);
        run_vec('{80'h5A, 6'd1, 1, 80'h5A000000000000000000}, "b2b");
        check("ign_b2b_done_count", 32'(done_cnt - db), 32'd2);

        // Reset during DATA bit 4 (cycles 21..24 after accept).
        mon_en = 1'b0;
        db = done_cnt;
        send_req(80'h0A, 6'd1);
        repeat (21) @(posedge clk);
        #2;
        check("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME) @(posedge clk);
        #1;
        check("mid_no_done", 32'(done_cnt - db), 32'd0);
        check("mid_tx_idle", 32'(tx), 32'd1);
        check("mid_busy_idle", 32'(busy), 32'd0);
        mon_en = 1'b1;
        run_vec(vecs[1], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_msg_tx.md
Name: uart_msg_tx

Overview:
- Downstream UART transmit stage for the pattern/button control block.
- Consumes that block's one-cycle `en_uart` request, its 80-bit right-aligned ASCII message and its byte count.
- Serialises the message as 8N1 (optionally 8E1) frames on the PC-facing TX pin.
- Reports busy/done to the top level.

Parameters:
- BAUD_DIV, 703, clocks per UART bit (81 MHz / 115200); legal range 2..65535.
- MSG_BYTES, 10, maximum message length in bytes; message bus width is 8*MSG_BYTES.
- GAP_BITS, 0, idle bit-times (tx=1) inserted between consecutive bytes of one message.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en_uart  in  1  start request; sampled every clk, level-high cycle = request.
- read_data  in  80  message; string is right-aligned, first character in the highest used byte.
- nummax  in  6  number of bytes to send.
- tx  out  1  UART serial output; idle high.
- busy  out  1  high from the accepted request until message end.
- done  out  1  one-cycle pulse at message end.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - tx=1, busy=0, done=0.
  - Internal state=IDLE, all counters and shift registers 0.
- Request acceptance:
  - A request is accepted only in IDLE with en_uart=1.
  - On that edge the block latches read_data and len = min(nummax, MSG_BYTES).
  - The byte index is set to len-1.
- Zero-length request: an accepted request with len=0 transmits nothing; done pulses on the next cycle and busy stays 0.
- Requests while busy=1 are ignored. There is no queueing, and latched data and length are unaffected.
- Byte order:
  - Byte k is latched_data[8k+7:8k].
  - Bytes are sent for k = len-1 down to 0.
  - Example: nummax=3 sends bits [23:16], then [15:8], then [7:0].
- Frame: start bit (0), then data bits LSB first, then [parity], then stop bit (1).
- Bit timing:
  - Each bit is held exactly BAUD_DIV clocks.
  - A baud counter runs 0..BAUD_DIV-1 and reloads to 0 on every state change.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP, GAP.
  - IDLE -> START on accept (len>0). tx=0 from the first cycle after the accept edge, so latency is 1 clk.
  - START -> DATA after BAUD_DIV clocks; the bit counter is cleared.
  - DATA: after BAUD_DIV clocks, shift to the next bit. After bit 7 go to PARITY, or to STOP when the feature is absent.
  - STOP, at its end:
    - If index=0: go to IDLE, busy=0, done=1 for one cycle.
    - Else if GAP_BITS>0: go to GAP.
    - Else: go to START with index-1.
  - GAP: tx=1 for GAP_BITS*BAUD_DIV clocks, then START with index-1.
- busy: high in every non-IDLE state. It falls in the same cycle done rises.
- Total message duration: len*(10+P+GAP_BITS)*BAUD_DIV - GAP_BITS*BAUD_DIV clocks, with P=1 if parity is enabled, else 0.
- A new request accepted in the cycle after done is legal (back-to-back messages).
- Reset asserted mid-frame: immediate return to reset values (tx=1 asynchronously); no partial frame is completed after release.
- nummax > MSG_BYTES is clamped to MSG_BYTES. The upper bits of nummax are otherwise don't-care.
- read_data and nummax may change freely after the accept edge without affecting the message in flight.

Optional Feature:
- Macro: UART_MSG_TX_PARITY_EN.
- Defined:
  - PARITY state present; one bit of BAUD_DIV clocks between bit 7 and stop.
  - Value = XOR of the 8 data bits (even parity). Frame is 11 bits.
- Undefined: no PARITY state and no parity logic synthesised; 8N1, 10-bit frame.

Test Plan:
- Single byte: BAUD_DIV=4, read_data=80'h0A, nummax=1, en_uart pulse.
  - tx = 0, then 0,1,0,1,0,0,0,0, then 1, each bit 4 clks; no parity.
  - done pulses at clk 41 after accept; busy high clks 1..40.
- Full string: read_data="\nA08-2_V4\n", nummax=10.
  - Decoded bytes 0A,41,30,38,2D,32,5F,56,34,0A in that order; exactly one done.
- Right-aligned short string: read_data="\n1\n", nummax=3 → bytes 0A,31,0A only.
  - nummax=0 → tx stays 1, done pulse 1 clk after accept, busy never high.
- Request while busy: second en_uart, with different data, issued mid-byte 2 of a 3-byte message.
  - Ignored; output is the original 3 bytes.
  - A new request the cycle after done is accepted and sent completely.
- Reset during DATA bit 4 → tx=1 immediately, busy=0, no done. After release a fresh request sends normally.
- With UART_MSG_TX_PARITY_EN and BAUD_DIV=4:
  - Byte 8'h31 → parity bit 1; byte 8'h0A → parity bit 0.
  - Frame length 44 clks per byte.
